// File: rtl/tr_axis_ctrl.sv
// Tracking-mode axis controller: position error -> profiled, slew-limited
// step rate -> phase-accumulator step pulses with safe direction reversal.
module tr_axis_ctrl #(
    parameter int WIDTH_IN   = 12,
    parameter int WIDTH_WORK = 16,
    parameter int ACC_W      = 24,
    parameter int DEADZONE   = 50,
    parameter int L_SHIFT    = 4,
    parameter int RAMP_STEP  = 64,
    parameter int PULSE_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tr_mode_enable,
    input  logic                  data_valid,
    input  logic [WIDTH_WORK-1:0] x,
    input  logic [WIDTH_IN-1:0]   x0,
    input  logic [WIDTH_WORK-1:0] dx1,
    input  logic [WIDTH_WORK-1:0] dx2,
    input  logic [WIDTH_WORK-1:0] F1,
    input  logic [WIDTH_WORK-1:0] F2,
    input  logic [WIDTH_WORK-1:0] k,
    output logic [WIDTH_WORK-1:0] n,
    output logic                  drv_dir,
    output logic                  drv_en_SM,
    output logic                  drv_step,
    output logic                  step_drop,
    output logic [1:0]            state_o
);

    localparam int W  = WIDTH_WORK;
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    x0_ext;
    logic [W-1:0]    dx_r;
    logic [W-1:0]    tgt_r;
    logic            c_r;
    logic            v1;
    logic            v2;
    logic            seen;
    logic [2*W-1:0]  prod;
    logic [2*W:0]    slope;
    logic [W-1:0]    prof;
    logic            rev;
    logic            up;
    logic [W-1:0]    diff;
    logic [W-1:0]    n_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]  sum;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            to_hold;

    assign x0_ext  = {{(W-WIDTH_IN){1'b0}}, x0};
    assign state_o = state;

    // c_r encodes "x above target", so it equals drv_dir exactly on reversal
    assign rev = (c_r == drv_dir);

    always_comb begin
        prod  = {{W{1'b0}}, k} * {{W{1'b0}}, dx_r - dx1};
        slope = {1'b0, prod >> L_SHIFT} + {{(W+1){1'b0}}, F1};
        if (dx_r >= dx2) begin
            prof = F2;
        end else if (dx_r >= dx1) begin
            prof = (slope > {{(W+1){1'b0}}, {W{1'b1}}}) ? {W{1'b1}}
                                                        : slope[W-1:0];
        end else if (dx_r > W'(DEADZONE)) begin
            prof = F1;
        end else begin
            prof = '0;
        end
    end

    always_comb begin
        up    = (tgt_r > n);
        diff  = up ? (tgt_r - n) : (n - tgt_r);
        n_nxt = tgt_r;
        if (diff > W'(RAMP_STEP)) begin
            n_nxt = up ? (n + W'(RAMP_STEP)) : (n - W'(RAMP_STEP));
        end
    end

    assign sum     = {1'b0, acc} + {{(ACC_W+1-W){1'b0}}, n};
    assign carry   = sum[ACC_W];
    assign to_hold = (state == TRACK) && v1 && (dx_r == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_r  <= '0;
            c_r   <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            seen  <= 1'b0;
            tgt_r <= '0;
        end else begin
            v1 <= data_valid;
            v2 <= v1;
            if (data_valid) begin
                dx_r <= (x > x0_ext) ? (x - x0_ext) : (x0_ext - x);
                c_r  <= (x > x0_ext);
                seen <= 1'b1;
            end
            if (v1) begin
                tgt_r <= rev ? '0 : prof;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            acc       <= '0;
            cnt       <= '0;
            drv_dir   <= 1'b0;
            drv_en_SM <= 1'b0;
            drv_step  <= 1'b0;
            step_drop <= 1'b0;
        end else if (!tr_mode_enable) begin
            state     <= IDLE;
            n         <= '0;
            acc       <= '0;
            cnt       <= '0;
            drv_en_SM <= 1'b0;
            drv_step  <= 1'b0;
            step_drop <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= TRACK;
                    drv_en_SM <= 1'b1;
                end
                TRACK: begin
                    if (to_hold) begin
                        state     <= HOLD;
                        drv_en_SM <= 1'b0;
                        n         <= '0;
                        acc       <= '0;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                        if (v2) n <= n_nxt;
                    end
                end
                HOLD: begin
                    if (v1 && dx_r >= W'(DEADZONE)) begin
                        state     <= TRACK;
                        drv_en_SM <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE) begin
                if (drv_step) begin
                    if (cnt == '0) drv_step <= 1'b0;
                    else           cnt      <= cnt - 1'b1;
                    if (carry && state == TRACK) step_drop <= 1'b1;
                end else if (carry && state == TRACK && !to_hold) begin
                    drv_step <= 1'b1;
                    cnt      <= CW'(PULSE_W - 1);
                end
            end
            // flip only once the axis has stopped and no pulse is in flight
            if (state != IDLE && seen && rev && n == '0 && !drv_step) begin
                drv_dir <= ~c_r;
            end
        end
    end

endmodule
